// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register and the EX-stage forwarding unit.
package id_ex_stage_pkg;

  localparam int ALUOP_W_DEF = 4;

  // Control bundle carried from ID into EX.
  typedef struct packed {
    logic                   reg_wr;
    logic                   mem_rd;
    logic                   mem_wr;
    logic                   branch;
    logic [ALUOP_W_DEF-1:0] alu_op;
  } ctrl_t;

  // A bubble has every control field cleared, so it cannot write or access memory.
  localparam ctrl_t BUBBLE_CTRL = '0;

  // Operand source selects used by the downstream forwarding unit.
  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the destination
// of a load currently sitting in EX. Pure combinational.
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_use_rs_i,
  input  logic              id_use_rt_i,
  input  logic              ex_valid_i,
  input  logic              ex_mem_rd_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  output logic              load_use_o
);

  logic rs_hit;
  logic rt_hit;

  // r0 is never a real producer, so a load targeting it cannot create a hazard.
  assign rs_hit     = id_use_rs_i && (id_rs_i == ex_rd_i);
  assign rt_hit     = id_use_rt_i && (id_rt_i == ex_rd_i);
  assign load_use_o = id_valid_i && ex_valid_i && ex_mem_rd_i &&
                      (ex_rd_i != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures the decoded instruction, inserts bubbles on
// flush or load-use, bypasses a same-cycle WB write into the operands, and
// counts load-use stall cycles.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int PC_W    = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = ALUOP_W_DEF,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ID_Valid,
  input  logic [PC_W-1:0]    ID_Pc,
  input  logic [REG_AW-1:0]  ID_Rs,
  input  logic [REG_AW-1:0]  ID_Rt,
  input  logic               ID_UseRs,
  input  logic               ID_UseRt,
  input  logic [DATA_W-1:0]  ID_RsData,
  input  logic [DATA_W-1:0]  ID_RtData,
  input  logic [DATA_W-1:0]  ID_Imm,
  input  logic               ID_RegWr,
  input  logic [REG_AW-1:0]  ID_RegWrAddr,
  input  logic               ID_MemRd,
  input  logic               ID_MemWr,
  input  logic               ID_Branch,
  input  logic [ALUOP_W-1:0] ID_AluOp,
  input  logic               MEM_WB_RegWr,
  input  logic [REG_AW-1:0]  MEM_WB_RegWrAddr,
  input  logic [DATA_W-1:0]  MEM_WB_WrData,
  input  logic               Flush,
  input  logic               Hold,
  output logic               Stall,
  output logic               ID_EX_Valid,
  output logic [PC_W-1:0]    ID_EX_Pc,
  output logic [REG_AW-1:0]  ID_EX_Rs,
  output logic [REG_AW-1:0]  ID_EX_Rt,
  output logic [DATA_W-1:0]  ID_EX_RsData,
  output logic [DATA_W-1:0]  ID_EX_RtData,
  output logic [DATA_W-1:0]  ID_EX_Imm,
  output logic               ID_EX_RegWr,
  output logic [REG_AW-1:0]  ID_EX_RegWrAddr,
  output logic               ID_EX_MemRd,
  output logic               ID_EX_MemWr,
  output logic               ID_EX_Branch,
  output logic [ALUOP_W-1:0] ID_EX_AluOp,
  output logic [CNT_W-1:0]   StallCnt
);

  logic              valid_q,   valid_d;
  logic [PC_W-1:0]   pc_q,      pc_d;
  logic [REG_AW-1:0] rs_q,      rs_d;
  logic [REG_AW-1:0] rt_q,      rt_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q,     imm_d;
  logic [REG_AW-1:0] rd_q,      rd_d;
  ctrl_t             ctrl_q,    ctrl_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;

  logic load_use;
  logic wb_hit_rs;
  logic wb_hit_rt;

  load_use_detect #(
    .REG_AW (REG_AW)
  ) u_load_use_detect (
    .id_valid_i  (ID_Valid),
    .id_rs_i     (ID_Rs),
    .id_rt_i     (ID_Rt),
    .id_use_rs_i (ID_UseRs),
    .id_use_rt_i (ID_UseRt),
    .ex_valid_i  (valid_q),
    .ex_mem_rd_i (ctrl_q.mem_rd),
    .ex_rd_i     (rd_q),
    .load_use_o  (load_use)
  );

  // Flush and Hold both suppress the freeze: a flush already kills the ID
  // instruction, and a hold freezes everything anyway.
  assign Stall = load_use && !Flush && !Hold;

  // WB writes this cycle are not yet visible in the regfile read data.
  assign wb_hit_rs = MEM_WB_RegWr && (MEM_WB_RegWrAddr != '0) && (MEM_WB_RegWrAddr == ID_Rs);
  assign wb_hit_rt = MEM_WB_RegWr && (MEM_WB_RegWrAddr != '0) && (MEM_WB_RegWrAddr == ID_Rt);

  // Next-state selection: Hold > Flush > LoadUse > normal capture.
  always_comb begin
    // NOTE: every variable assigned here gets a default first, otherwise a
    // path that skips it would infer a latch.
    valid_d   = valid_q;
    pc_d      = pc_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    rd_d      = rd_q;
    ctrl_d    = ctrl_q;
    cnt_d     = cnt_q;

    if (Hold) begin
      // keep everything, no counting
    end else if (Flush || load_use) begin
      valid_d   = 1'b0;
      pc_d      = '0;
      rs_d      = '0;
      rt_d      = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      rd_d      = '0;
      ctrl_d    = BUBBLE_CTRL;
      // A flushed instruction never re-presents, so it is not a stall cycle.
      if (!Flush && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      valid_d        = ID_Valid;
      pc_d           = ID_Pc;
      rs_d           = ID_Rs;
      rt_d           = ID_Rt;
      rs_data_d      = wb_hit_rs ? MEM_WB_WrData : ID_RsData;
      rt_data_d      = wb_hit_rt ? MEM_WB_WrData : ID_RtData;
      imm_d          = ID_Imm;
      rd_d           = ID_RegWrAddr;
      ctrl_d.reg_wr  = ID_Valid && ID_RegWr && (ID_RegWrAddr != '0);
      ctrl_d.mem_rd  = ID_Valid && ID_MemRd;
      ctrl_d.mem_wr  = ID_Valid && ID_MemWr;
      ctrl_d.branch  = ID_Valid && ID_Branch;
      ctrl_d.alu_op  = ID_AluOp;
    end
  end

  // Pipeline register and stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register here has an explicit reset value; outputs must read
    // zero as soon as rst_n falls, without waiting for a clock edge.
    if (!rst_n) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rd_q      <= '0;
      ctrl_q    <= BUBBLE_CTRL;
      cnt_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rd_q      <= rd_d;
      ctrl_q    <= ctrl_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ID_EX_Valid     = valid_q;
  assign ID_EX_Pc        = pc_q;
  assign ID_EX_Rs        = rs_q;
  assign ID_EX_Rt        = rt_q;
  assign ID_EX_RsData    = rs_data_q;
  assign ID_EX_RtData    = rt_data_q;
  assign ID_EX_Imm       = imm_q;
  assign ID_EX_RegWr     = ctrl_q.reg_wr;
  assign ID_EX_RegWrAddr = rd_q;
  assign ID_EX_MemRd     = ctrl_q.mem_rd;
  assign ID_EX_MemWr     = ctrl_q.mem_wr;
  assign ID_EX_Branch    = ctrl_q.branch;
  assign ID_EX_AluOp     = ctrl_q.alu_op;
  assign StallCnt        = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard scenarios followed by
// randomized traffic, all compared against a behavioural model of the EX slot.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ID_Valid;
  logic [31:0] ID_Pc;
  logic [4:0]  ID_Rs, ID_Rt;
  logic        ID_UseRs, ID_UseRt;
  logic [31:0] ID_RsData, ID_RtData, ID_Imm;
  logic        ID_RegWr;
  logic [4:0]  ID_RegWrAddr;
  logic        ID_MemRd, ID_MemWr, ID_Branch;
  logic [3:0]  ID_AluOp;
  logic        MEM_WB_RegWr;
  logic [4:0]  MEM_WB_RegWrAddr;
  logic [31:0] MEM_WB_WrData;
  logic        Flush, Hold;
  logic        Stall;
  logic        ID_EX_Valid;
  logic [31:0] ID_EX_Pc;
  logic [4:0]  ID_EX_Rs, ID_EX_Rt;
  logic [31:0] ID_EX_RsData, ID_EX_RtData, ID_EX_Imm;
  logic        ID_EX_RegWr;
  logic [4:0]  ID_EX_RegWrAddr;
  logic        ID_EX_MemRd, ID_EX_MemWr, ID_EX_Branch;
  logic [3:0]  ID_EX_AluOp;
  logic [31:0] StallCnt;

  id_ex_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ID_Valid         (ID_Valid),
    .ID_Pc            (ID_Pc),
    .ID_Rs            (ID_Rs),
    .ID_Rt            (ID_Rt),
    .ID_UseRs         (ID_UseRs),
    .ID_UseRt         (ID_UseRt),
    .ID_RsData        (ID_RsData),
    .ID_RtData        (ID_RtData),
    .ID_Imm           (ID_Imm),
    .ID_RegWr         (ID_RegWr),
    .ID_RegWrAddr     (ID_RegWrAddr),
    .ID_MemRd         (ID_MemRd),
    .ID_MemWr         (ID_MemWr),
    .ID_Branch        (ID_Branch),
    .ID_AluOp         (ID_AluOp),
    .MEM_WB_RegWr     (MEM_WB_RegWr),
    .MEM_WB_RegWrAddr (MEM_WB_RegWrAddr),
    .MEM_WB_WrData    (MEM_WB_WrData),
    .Flush            (Flush),
    .Hold             (Hold),
    .Stall            (Stall),
    .ID_EX_Valid      (ID_EX_Valid),
    .ID_EX_Pc         (ID_EX_Pc),
    .ID_EX_Rs         (ID_EX_Rs),
    .ID_EX_Rt         (ID_EX_Rt),
    .ID_EX_RsData     (ID_EX_RsData),
    .ID_EX_RtData     (ID_EX_RtData),
    .ID_EX_Imm        (ID_EX_Imm),
    .ID_EX_RegWr      (ID_EX_RegWr),
    .ID_EX_RegWrAddr  (ID_EX_RegWrAddr),
    .ID_EX_MemRd      (ID_EX_MemRd),
    .ID_EX_MemWr      (ID_EX_MemWr),
    .ID_EX_Branch     (ID_EX_Branch),
    .ID_EX_AluOp      (ID_EX_AluOp),
    .StallCnt         (StallCnt)
  );

  always #5 clk = ~clk;

  // Expected contents of the EX slot.
  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs, rt;
    logic [31:0] rsd, rtd, imm;
    logic        regwr;
    logic [4:0]  rd;
    logic        memrd, memwr, branch;
    logic [3:0]  aluop;
  } slot_t;

  slot_t       m;
  slot_t       empty_slot;
  logic [31:0] m_cnt;
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic slot_t clear_slot();
    slot_t s;
    s.valid = 0; s.pc = 0; s.rs = 0; s.rt = 0; s.rsd = 0; s.rtd = 0; s.imm = 0;
    s.regwr = 0; s.rd = 0; s.memrd = 0; s.memwr = 0; s.branch = 0; s.aluop = 0;
    return s;
  endfunction

  // Does the instruction in ID read the register a pending load will produce?
  function automatic bit model_load_use();
    if (!(ID_Valid && m.valid && m.memrd) || m.rd == 0) return 0;
    return (ID_UseRs && ID_Rs == m.rd) || (ID_UseRt && ID_Rt == m.rd);
  endfunction

  // Value the EX stage should see for a source register: a WB write this cycle wins.
  function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] rf_val);
    if (MEM_WB_RegWr && MEM_WB_RegWrAddr != 0 && MEM_WB_RegWrAddr == r) return MEM_WB_WrData;
    return rf_val;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".Valid"},  {31'd0, ID_EX_Valid},  {31'd0, m.valid});
    check({tag, ".Pc"},     ID_EX_Pc,              m.pc);
    check({tag, ".Rs"},     {27'd0, ID_EX_Rs},     {27'd0, m.rs});
    check({tag, ".Rt"},     {27'd0, ID_EX_Rt},     {27'd0, m.rt});
    check({tag, ".RsData"}, ID_EX_RsData,          m.rsd);
    check({tag, ".RtData"}, ID_EX_RtData,          m.rtd);
    check({tag, ".Imm"},    ID_EX_Imm,             m.imm);
    check({tag, ".RegWr"},  {31'd0, ID_EX_RegWr},  {31'd0, m.regwr});
    check({tag, ".Rd"},     {27'd0, ID_EX_RegWrAddr}, {27'd0, m.rd});
    check({tag, ".MemRd"},  {31'd0, ID_EX_MemRd},  {31'd0, m.memrd});
    check({tag, ".MemWr"},  {31'd0, ID_EX_MemWr},  {31'd0, m.memwr});
    check({tag, ".Branch"}, {31'd0, ID_EX_Branch}, {31'd0, m.branch});
    check({tag, ".AluOp"},  {28'd0, ID_EX_AluOp},  {28'd0, m.aluop});
    check({tag, ".Cnt"},    StallCnt,              m_cnt);
  endtask

  // One clock: check Stall against the model, advance the model, check registers.
  task automatic cycle(input string tag);
    bit lu;
    #1;
    lu = model_load_use();
    check({tag, ".Stall"}, {31'd0, Stall}, {31'd0, lu && !Flush && !Hold});
    if (Hold) begin
      // frozen
    end else if (Flush) begin
      m = empty_slot;
    end else if (lu) begin
      m = empty_slot;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end else begin
      m.valid  = ID_Valid;
      m.pc     = ID_Pc;
      m.rs     = ID_Rs;
      m.rt     = ID_Rt;
      m.rsd    = operand(ID_Rs, ID_RsData);
      m.rtd    = operand(ID_Rt, ID_RtData);
      m.imm    = ID_Imm;
      m.rd     = ID_RegWrAddr;
      m.regwr  = ID_Valid && ID_RegWr && ID_RegWrAddr != 0;
      m.memrd  = ID_Valid && ID_MemRd;
      m.memwr  = ID_Valid && ID_MemWr;
      m.branch = ID_Valid && ID_Branch;
      m.aluop  = ID_AluOp;
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle_inputs();
    ID_Valid = 0; ID_Pc = 0; ID_Rs = 0; ID_Rt = 0; ID_UseRs = 0; ID_UseRt = 0;
    ID_RsData = 0; ID_RtData = 0; ID_Imm = 0; ID_RegWr = 0; ID_RegWrAddr = 0;
    ID_MemRd = 0; ID_MemWr = 0; ID_Branch = 0; ID_AluOp = 0;
    MEM_WB_RegWr = 0; MEM_WB_RegWrAddr = 0; MEM_WB_WrData = 0;
    Flush = 0; Hold = 0;
  endtask

  task automatic load(input logic [4:0] rd, input logic [31:0] pc);
    idle_inputs();
    ID_Valid = 1; ID_Pc = pc; ID_Rs = 5'd2; ID_UseRs = 1; ID_Imm = 32'h10;
    ID_RegWr = 1; ID_RegWrAddr = rd; ID_MemRd = 1; ID_AluOp = 4'h1;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [31:0] pc);
    idle_inputs();
    ID_Valid = 1; ID_Pc = pc; ID_Rs = rs; ID_Rt = rt; ID_UseRs = 1; ID_UseRt = 1;
    ID_RsData = 32'h1111_0000 + 32'(rs); ID_RtData = 32'h2222_0000 + 32'(rt);
    ID_RegWr = 1; ID_RegWrAddr = rd; ID_AluOp = 4'h3;
  endtask

  task automatic random_inputs();
    ID_Valid         = ($urandom_range(0, 9) != 0);
    ID_Pc            = $urandom;
    ID_Rs            = 5'($urandom_range(0, 7));
    ID_Rt            = 5'($urandom_range(0, 7));
    ID_UseRs         = 1'($urandom);
    ID_UseRt         = 1'($urandom);
    ID_RsData        = $urandom;
    ID_RtData        = $urandom;
    ID_Imm           = $urandom;
    ID_RegWr         = 1'($urandom);
    ID_RegWrAddr     = 5'($urandom_range(0, 7));
    ID_MemRd         = ($urandom_range(0, 2) == 0);
    ID_MemWr         = ($urandom_range(0, 3) == 0);
    ID_Branch        = ($urandom_range(0, 3) == 0);
    ID_AluOp         = 4'($urandom);
    MEM_WB_RegWr     = 1'($urandom);
    MEM_WB_RegWrAddr = 5'($urandom_range(0, 7));
    MEM_WB_WrData    = $urandom;
    Flush            = ($urandom_range(0, 7) == 0);
    Hold             = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    empty_slot = clear_slot();
    m     = empty_slot;
    m_cnt = 0;
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rst_n = 1;

    // Load r5 followed by a dependent add: one bubble, then the add proceeds.
    load(5'd5, 32'h100);
    cycle("ld_r5");
    alu(5'd6, 5'd5, 5'd7, 32'h104);
    #1;
    check("lu.stall_now", {31'd0, Stall}, 32'd1);
    cycle("lu.bubble");
    check("lu.bubble_valid", {31'd0, ID_EX_Valid}, 32'd0);
    check("lu.cnt_one", StallCnt, 32'd1);
    cycle("lu.add_enters");
    check("lu.add_valid", {31'd0, ID_EX_Valid}, 32'd1);
    check("lu.add_rd", {27'd0, ID_EX_RegWrAddr}, 32'd6);

    // Load into r0 never creates a hazard.
    load(5'd0, 32'h200);
    cycle("ld_r0");
    check("r0.regwr_dropped", {31'd0, ID_EX_RegWr}, 32'd0);
    alu(5'd8, 5'd0, 5'd0, 32'h204);
    #1;
    check("r0.no_stall", {31'd0, Stall}, 32'd0);
    cycle("r0.use");
    check("r0.use_valid", {31'd0, ID_EX_Valid}, 32'd1);

    // WB write of r3 overrides stale regfile data on capture.
    alu(5'd9, 5'd3, 5'd4, 32'h300);
    ID_RsData = 32'h1;
    MEM_WB_RegWr = 1; MEM_WB_RegWrAddr = 5'd3; MEM_WB_WrData = 32'hDEAD_BEEF;
    cycle("wb_bypass");
    check("wb.rsdata", ID_EX_RsData, 32'hDEAD_BEEF);

    // Flush coinciding with a load-use: a single bubble, no stall, no count.
    load(5'd5, 32'h400);
    cycle("ld_r5_b");
    alu(5'd6, 5'd5, 5'd7, 32'h404);
    Flush = 1;
    cycle("flush_lu");
    check("flush.valid", {31'd0, ID_EX_Valid}, 32'd0);
    check("flush.cnt", StallCnt, 32'd1);

    // Hold for three cycles over a pending load-use, then release.
    load(5'd5, 32'h500);
    cycle("ld_r5_c");
    alu(5'd6, 5'd5, 5'd7, 32'h504);
    Hold = 1;
    for (int i = 0; i < 3; i++) cycle("hold");
    check("hold.frozen_memrd", {31'd0, ID_EX_MemRd}, 32'd1);
    check("hold.frozen_pc", ID_EX_Pc, 32'h500);
    Hold = 0;
    cycle("hold_release");
    check("hold.cnt", StallCnt, 32'd2);
    cycle("hold_after");
    check("hold.add_pc", ID_EX_Pc, 32'h504);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      random_inputs();
      cycle("rand");
    end

    // Asynchronous reset between edges.
    random_inputs();
    Hold = 0; Flush = 0;
    for (int i = 0; i < 3; i++) cycle("pre_rst");
    #2;
    rst_n = 0;
    #1;
    m     = empty_slot;
    m_cnt = 0;
    check_outputs("async_rst");
    #1;
    rst_n = 1;
    for (int i = 0; i < 50; i++) begin
      random_inputs();
      cycle("post_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
